// File: rtl/qmulti_pkg.sv
// Common parameters and helpers for the pipelined sign-magnitude multiplier.
package qmulti_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_FRAC  = 16;

    localparam logic [31:0] Q16_ONE  = 32'h00010000;
    localparam logic [31:0] Q16_HALF = 32'h00008000;

    // Full product width of two (width-1)-bit magnitudes.
    function automatic int prod_width(input int width);
        return 2 * (width - 1);
    endfunction

endpackage

// File: rtl/qmulti_defs.vh
// Shared defaults and Q16.16 constants for the qmulti family; guarded so any
// number of files can pull it in.
`ifndef QMULTI_DEFS_VH
`define QMULTI_DEFS_VH

`define QMULTI_WIDTH 32
`define QMULTI_FRAC  16

`define QMULTI_SM(sign_bit, magnitude) {(sign_bit), (magnitude)}

`define QMULTI_ONE  32'h00010000
`define QMULTI_HALF 32'h00008000

`endif

// File: rtl/qmulti_round_sat.sv
// Final-stage arithmetic: scale the full product down by FRAC, optionally
// round and saturate, and rebuild a sign-magnitude word without negative zero.
module qmulti_round_sat
    import qmulti_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC,
    parameter int ROUND = 1,
    parameter int SAT   = 1
) (
    input  logic [prod_width(WIDTH)-1:0] prod,
    input  logic                         sign,
    output logic [WIDTH-1:0]             result,
    output logic                         ovf
);

    localparam int PW = prod_width(WIDTH);

    // One spare bit on top so the rounding increment can never wrap.
    logic [PW:0]      q_ext;
    logic [WIDTH-2:0] mag;

    always_comb begin
        q_ext = {1'b0, prod} >> FRAC;
        if (ROUND != 0) begin
            q_ext = q_ext + {{PW{1'b0}}, prod[FRAC-1]};
        end
        ovf = |q_ext[PW:WIDTH-1];
        if ((SAT != 0) && ovf) begin
            mag = '1;
        end else begin
            mag = q_ext[WIDTH-2:0];
        end
        result = {sign & (|mag), mag};
    end

endmodule

// File: rtl/qmulti_pipe.sv
// Three-stage valid/ready sign-magnitude fixed-point multiplier: operand
// register, product register, rounded/saturated result register.
module qmulti_pipe
    import qmulti_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC,
    parameter int ROUND = 1,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] multi1,
    input  logic [WIDTH-1:0] multi2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int PW = prod_width(WIDTH);

    logic             s1_valid;
    logic [WIDTH-2:0] s1_mag_a;
    logic [WIDTH-2:0] s1_mag_b;
    logic             s1_sign;

    logic             s2_valid;
    logic [PW-1:0]    s2_prod;
    logic             s2_sign;

    logic             s3_valid;

    logic             s1_free;
    logic             s2_free;
    logic             s3_free;

    logic [WIDTH-1:0] rs_result;
    logic             rs_ovf;

    // A stage may load when it is empty or its contents leave on this edge;
    // chaining these lets bubbles collapse and keeps full-rate flow.
    assign s3_free  = !s3_valid || out_ready;
    assign s2_free  = !s2_valid || s3_free;
    assign s1_free  = !s1_valid || s2_free;
    assign in_ready = s1_free;

    assign out_valid = s3_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mag_a <= '0;
            s1_mag_b <= '0;
            s1_sign  <= 1'b0;
        end else if (s1_free) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mag_a <= multi1[WIDTH-2:0];
                s1_mag_b <= multi2[WIDTH-2:0];
                s1_sign  <= multi1[WIDTH-1] ^ multi2[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_sign  <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_prod <= PW'(s1_mag_a) * PW'(s1_mag_b);
                s2_sign <= s1_sign;
            end
        end
    end

    qmulti_round_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ROUND (ROUND),
        .SAT   (SAT)
    ) u_round_sat (
        .prod   (s2_prod),
        .sign   (s2_sign),
        .result (rs_result),
        .ovf    (rs_ovf)
    );

    // Result only changes when a new product is loaded, so it holds under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else if (s3_free) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                result   <= rs_result;
                overflow <= rs_ovf;
            end
        end
    end

endmodule
